// File: rtl/sgm_cost_pkg.sv
// Shared widths, saturation constant and the winner-take-all tree node type
// for the cost fusion / WTA block.
package sgm_cost_pkg;

  localparam int D_DFLT      = 256;
  localparam int HAM_W_DFLT  = 4;
  localparam int GRAD_W_DFLT = 12;
  localparam int COST_W_DFLT = 10;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int IDX_W = idx_w(D_DFLT);

  localparam logic [COST_W_DFLT-1:0] COST_MAX = '1;

  // Sized for the largest supported D; smaller trees leave the upper idx bits zero.
  typedef struct packed {
    logic [COST_W_DFLT-1:0] cost;
    logic [IDX_W-1:0]       idx;
    logic [COST_W_DFLT-1:0] second;
  } wta_node_t;

endpackage

// File: rtl/cost_fuse_wta_if.sv
// Pixel-stream bundle between the cost stage, the fusion/WTA block and the
// disparity consumer.
interface cost_fuse_wta_if
  import sgm_cost_pkg::*;
#(
  parameter int D      = D_DFLT,
  parameter int HAM_W  = HAM_W_DFLT,
  parameter int GRAD_W = GRAD_W_DFLT,
  parameter int COST_W = COST_W_DFLT
);

  logic                    in_valid;
  logic [D*HAM_W-1:0]      hamming;
  logic [D*GRAD_W-1:0]     cost_grad;
  logic                    out_valid;
  logic [$clog2(D)-1:0]    disp;
  logic [COST_W-1:0]       min_cost;
  logic                    disp_invalid;

  modport master (
    output in_valid, hamming, cost_grad,
    input  out_valid, disp, min_cost, disp_invalid
  );

  modport slave (
    input  in_valid, hamming, cost_grad,
    output out_valid, disp, min_cost, disp_invalid
  );

endinterface

// File: rtl/wta_cmp_node.sv
// One registered winner-take-all tree node: forwards the lower-cost input,
// lower index on a tie. Second-best tracking only when WTA_UNIQUE_EN is defined.
module wta_cmp_node
  import sgm_cost_pkg::*;
#(
  parameter bit RST_EN = 1'b0
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clken,
  input  logic      ld,
  input  wta_node_t a,
  input  wta_node_t b,
  output wta_node_t q
);

  localparam wta_node_t RST_VAL = '{cost: '0, idx: '0, second: COST_MAX};

  logic      a_wins;
  wta_node_t nxt;

`ifdef WTA_UNIQUE_EN
  logic [COST_W_DFLT-1:0] lose_cost;
  logic [COST_W_DFLT-1:0] sec;
`else
  logic unused_sec;
  assign unused_sec = ^{a.second, b.second};
`endif

  // Input a always carries the lower index, so it wins ties.
  always_comb begin
    a_wins = (a.cost <= b.cost);
    nxt    = a_wins ? a : b;
`ifdef WTA_UNIQUE_EN
    lose_cost = a_wins ? b.cost : a.cost;
    sec       = lose_cost;
    if (a.second < sec) sec = a.second;
    if (b.second < sec) sec = b.second;
    nxt.second = sec;
`else
    nxt.second = COST_MAX;
`endif
  end

  always_ff @(posedge clk) begin
    if (RST_EN && rst) begin
      q <= RST_VAL;
    end else if (clken && ld) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/cost_fuse_wta.sv
// Fuses census-Hamming and gradient costs per disparity and picks the winner
// through a log2(D)-deep registered tree. Optional uniqueness check: WTA_UNIQUE_EN.
module cost_fuse_wta
  import sgm_cost_pkg::*;
#(
  parameter int D           = D_DFLT,
  parameter int HAM_W       = HAM_W_DFLT,
  parameter int GRAD_W      = GRAD_W_DFLT,
  parameter int COST_W      = COST_W_DFLT,
  parameter int W_HAM       = 8,
  parameter int GRAD_SHIFT  = 3,
  parameter int UNIQ_MARGIN = 4
) (
  input logic             sys_clk,
  input logic             sys_rst,
  input logic             clken,
  cost_fuse_wta_if.slave  bus
);

  localparam int LOG_D = $clog2(D);
  localparam int ROOT  = D - 2;
  localparam logic signed [COST_W:0] MARGIN_S = (COST_W+1)'(UNIQ_MARGIN);

  function automatic logic [COST_W-1:0] sat_fuse(input logic [HAM_W-1:0]  h,
                                                 input logic [GRAD_W-1:0] g);
    logic [31:0] sum;
    sum = 32'(h) * 32'(W_HAM) + 32'(g >> GRAD_SHIFT);
    return (sum > 32'(COST_MAX)) ? COST_MAX : sum[COST_W-1:0];
  endfunction

  // Offset of tree level l (1..LOG_D) inside the flat node array.
  function automatic int lvl_off(input int l);
    return D - ((2 * D) >> l);
  endfunction

  logic [LOG_D:0] vld_p;
  wta_node_t      fuse_p0 [D];
  wta_node_t      tree_q  [D-1];
  wta_node_t      root;
  logic           unused_root;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      vld_p <= '0;
    end else if (clken) begin
      vld_p <= {vld_p[LOG_D-1:0], bus.in_valid};
    end
  end

  // ---- stage p0: fusion + saturation ----
  always_ff @(posedge sys_clk) begin
    if (clken) begin
      for (int d = 0; d < D; d++) begin
        fuse_p0[d] <= '{cost:   sat_fuse(bus.hamming[d*HAM_W +: HAM_W],
                                         bus.cost_grad[d*GRAD_W +: GRAD_W]),
                        idx:    IDX_W'(d),
                        second: COST_MAX};
      end
    end
  end

  // ---- stages p1..pLOG_D: comparator tree, root holds between valid beats ----
  for (genvar l = 1; l <= LOG_D; l++) begin : g_lvl
    for (genvar n = 0; n < (D >> l); n++) begin : g_node
      wta_node_t node_a;
      wta_node_t node_b;
      if (l == 1) begin : g_leaf
        assign node_a = fuse_p0[2*n];
        assign node_b = fuse_p0[2*n+1];
      end else begin : g_inner
        assign node_a = tree_q[lvl_off(l-1) + 2*n];
        assign node_b = tree_q[lvl_off(l-1) + 2*n + 1];
      end
      wta_cmp_node #(.RST_EN(l == LOG_D)) u_node (
        .clk   (sys_clk),
        .rst   (sys_rst),
        .clken (clken),
        .ld    ((l == LOG_D) ? vld_p[LOG_D-1] : 1'b1),
        .a     (node_a),
        .b     (node_b),
        .q     (tree_q[lvl_off(l) + n])
      );
    end
  end

  assign root          = tree_q[ROOT];
  assign bus.out_valid = vld_p[LOG_D];
  assign bus.disp      = root.idx[LOG_D-1:0];
  assign bus.min_cost  = root.cost;

`ifdef WTA_UNIQUE_EN
  logic signed [COST_W:0] gap;
  assign gap              = $signed({1'b0, root.second}) - $signed({1'b0, root.cost});
  assign bus.disp_invalid = (gap < MARGIN_S);
  assign unused_root      = ^root.idx;
`else
  assign bus.disp_invalid = 1'b0;
  assign unused_root      = ^{root.idx, root.second, MARGIN_S};
`endif

endmodule

// File: tb/tb_cost_fuse_wta.sv
// Randomised and directed bench for cost_fuse_wta against a flat min-search
// reference model; a second D=2 instance covers saturation and the single-level tree.
module tb_cost_fuse_wta;

  localparam int D    = 256;
  localparam int HW   = 4;
  localparam int GW   = 12;
  localparam int CW   = 10;
  localparam int WH   = 8;
  localparam int GS   = 3;
  localparam int UM   = 4;
  localparam int CMAX = 1023;
  localparam int WH2  = 64;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic clken   = 1'b1;

  always #5 sys_clk = ~sys_clk;

  cost_fuse_wta_if #(.D(D), .HAM_W(HW), .GRAD_W(GW), .COST_W(CW)) bus  ();
  cost_fuse_wta_if #(.D(2), .HAM_W(HW), .GRAD_W(GW), .COST_W(CW)) bus2 ();

  cost_fuse_wta #(.D(D), .HAM_W(HW), .GRAD_W(GW), .COST_W(CW),
                  .W_HAM(WH), .GRAD_SHIFT(GS), .UNIQ_MARGIN(UM)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clken   (clken),
    .bus     (bus)
  );

  cost_fuse_wta #(.D(2), .HAM_W(HW), .GRAD_W(GW), .COST_W(CW),
                  .W_HAM(WH2), .GRAD_SHIFT(GS), .UNIQ_MARGIN(UM)) dut2 (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .clken   (clken),
    .bus     (bus2)
  );

  typedef struct {
    int disp;
    int cost;
    int inv;
  } exp_t;

  exp_t              exp_q[$];
  int                n_cmp = 0;
  int                n_bad = 0;
  logic [D*HW-1:0]   ham_v;
  logic [D*GW-1:0]   grad_v;
  logic              iv_drv = 1'b0;
  logic              prev_ov = 1'b0;
  int                prev_disp = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic put(input int d, input int h, input int g);
    ham_v[d*HW +: HW]  = HW'(h);
    grad_v[d*GW +: GW] = GW'(g);
  endtask

  task automatic fill(input int h, input int g);
    for (int d = 0; d < D; d++) put(d, h, g);
  endtask

  function automatic exp_t model();
    exp_t e;
    int   c [D];
    int   bi;
    int   sec;
    for (int d = 0; d < D; d++) begin
      c[d] = int'(ham_v[d*HW +: HW]) * WH + int'(grad_v[d*GW +: GW]) / (1 << GS);
      if (c[d] > CMAX) c[d] = CMAX;
    end
    bi = 0;
    for (int d = 1; d < D; d++) if (c[d] < c[bi]) bi = d;
    sec = CMAX;
    for (int d = 0; d < D; d++) if (d != bi && c[d] < sec) sec = c[d];
    e.disp = bi;
    e.cost = c[bi];
`ifdef WTA_UNIQUE_EN
    e.inv = ((sec - c[bi]) < UM) ? 1 : 0;
`else
    e.inv = 0;
`endif
    return e;
  endfunction

  task automatic step();
    logic ce, rv, iv;
    exp_t e, o;
    bus.hamming   = ham_v;
    bus.cost_grad = grad_v;
    bus.in_valid  = iv_drv;
    ce = clken;
    rv = sys_rst;
    iv = iv_drv;
    if (iv && ce && !rv) e = model();
    @(posedge sys_clk);
    #1;
    if (rv) begin
      exp_q.delete();
      check_val("rst_out_valid", bus.out_valid, 0);
      check_val("rst_disp", bus.disp, 0);
      check_val("rst_min_cost", bus.min_cost, 0);
      check_val("rst_disp_invalid", bus.disp_invalid, 0);
    end else if (ce) begin
      if (iv) exp_q.push_back(e);
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check_val("spurious_out_valid", bus.out_valid, 0);
        end else begin
          o = exp_q.pop_front();
          check_val("disp", bus.disp, o.disp);
          check_val("min_cost", bus.min_cost, o.cost);
          check_val("disp_invalid", bus.disp_invalid, o.inv);
        end
      end
    end else begin
      check_val("stall_hold_valid", bus.out_valid, prev_ov);
      check_val("stall_hold_disp", bus.disp, prev_disp);
    end
    prev_ov   = bus.out_valid;
    prev_disp = int'(bus.disp);
  endtask

  task automatic drain();
    iv_drv = 1'b0;
    repeat (12) step();
    check_val("drain_empty", exp_q.size(), 0);
  endtask

  function automatic int fuse2(input int h, input int g);
    int s;
    s = h * WH2 + g / (1 << GS);
    return (s > CMAX) ? CMAX : s;
  endfunction

  int lat, nz, cnt;
  int bub [4] = '{1, 0, 1, 1};
  int c2h0 [3] = '{15, 15, 3};
  int c2g0 [3] = '{4095, 0, 8};
  int c2h1 [3] = '{15, 2, 3};
  int c2g1 [3] = '{4095, 80, 8};

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, c1, bd, bc, sc;
    bus.in_valid   = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.hamming   = '0;
    bus2.cost_grad = '0;
    fill(15, 4095);

    sys_rst = 1'b1;
    repeat (3) step();
    sys_rst = 1'b0;

    // Latency from the sampling edge to out_valid, outputs untouched before it.
    fill(15, 4095);
    put(37, 2, 16);
    bus.hamming   = ham_v;
    bus.cost_grad = grad_v;
    bus.in_valid  = 1'b1;
    @(posedge sys_clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    nz  = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.disp != 0 || bus.min_cost != 0) nz++;
      @(posedge sys_clk);
      #1;
      lat++;
    end
    check_val("latency", lat, 9);
    check_val("lat_disp", bus.disp, 37);
    check_val("lat_min_cost", bus.min_cost, 2 * WH + 16 / (1 << GS));
    check_val("pre_valid_outputs_zero", nz, 0);
    prev_ov = bus.out_valid;

    // Directed vectors: fusion arithmetic, all-max, tie, uniqueness margin.
    iv_drv = 1'b1;
    fill(15, 4095); put(5, 3, 40);                  step();
    fill(15, 4095);                                 step();
    fill(15, 4095); put(200, 1, 32); put(17, 1, 32); step();
    fill(15, 4095); put(10, 6, 16); put(90, 6, 32); step();
    fill(15, 4095); put(10, 6, 16); put(90, 7, 32); step();
    fill(0, 0);                                     step();
    drain();

    // Bubble pattern.
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < D; d++) put(d, $urandom_range(0, 15), $urandom_range(0, 4095));
      iv_drv = bub[i][0];
      step();
    end
    drain();

    // Ramp of winners with a clken stall mid-stream.
    for (int k = 0; k < 20; k++) begin
      fill(15, 4095);
      put(k, 1, 0);
      iv_drv = 1'b1;
      if (k == 10) begin
        clken = 1'b0;
        repeat (5) step();
        clken = 1'b1;
      end
      step();
    end
    drain();

    // Random narrow-range costs give frequent ties and near-ties.
    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < D; d++) put(d, $urandom_range(0, 3), $urandom_range(0, 63));
      iv_drv = ($urandom_range(0, 3) != 0);
      clken  = ($urandom_range(0, 7) != 0);
      step();
    end
    clken = 1'b1;
    drain();

    // Reset three cycles after the last input discards everything in flight.
    for (int i = 0; i < 4; i++) begin
      fill(15, 4095);
      put(i + 100, 0, 8);
      iv_drv = bub[i][0];
      step();
    end
    iv_drv = 1'b0;
    repeat (3) step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.out_valid) cnt++;
    end
    check_val("reset_flush_out_valid", cnt, 0);

    // D=2 instance with a heavier Hamming weight so saturation is reachable.
    for (int i = 0; i < 3; i++) begin
      c0 = fuse2(c2h0[i], c2g0[i]);
      c1 = fuse2(c2h1[i], c2g1[i]);
      bd = (c1 < c0) ? 1 : 0;
      bc = (c1 < c0) ? c1 : c0;
      sc = (c1 < c0) ? c0 : c1;
      bus2.hamming   = {HW'(c2h1[i]), HW'(c2h0[i])};
      bus2.cost_grad = {GW'(c2g1[i]), GW'(c2g0[i])};
      bus2.in_valid  = 1'b1;
      @(posedge sys_clk);
      #1;
      bus2.in_valid = 1'b0;
      check_val("d2_early_valid", bus2.out_valid, 0);
      @(posedge sys_clk);
      #1;
      check_val("d2_out_valid", bus2.out_valid, 1);
      check_val("d2_disp", bus2.disp, bd);
      check_val("d2_min_cost", bus2.min_cost, bc);
`ifdef WTA_UNIQUE_EN
      check_val("d2_disp_invalid", bus2.disp_invalid, ((sc - bc) < UM) ? 1 : 0);
`else
      check_val("d2_disp_invalid", bus2.disp_invalid, 0);
`endif
      @(posedge sys_clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
